uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Serial-to-parallel UART receiver (8N1 by default), the receive end of the rx_tx_lab serial link.
//  Generates its own oversample tick with a free-running clk divider and centre-samples each bit.
//  Presents each received byte on a valid/ready handshake to downstream logic (display, echo TX).
// PARAMETERS
//  TICK_DIV    651  clk cycles per oversample tick (100 MHz / (9600*16)); legal range >= 2
//  OVERSAMPLE  16   ticks per bit period; even, >= 4
//  DATA_BITS   8    payload bits per frame, LSB first; legal range 5..9
// PORTS
//  clk        in   1          system clock, 100 MHz
//  rst_n      in   1          asynchronous active-low reset
//  rx         in   1          serial line, idle high, asynchronous to clk
//  rx_data    out  DATA_BITS  last good byte; stable while rx_valid=1
//  rx_valid   out  1          byte available; held until accepted
//  rx_ready   in   1          consumer accepts byte when rx_valid & rx_ready at posedge clk
//  frame_err  out  1          1-clk pulse: stop bit sampled low
//  overrun    out  1          1-clk pulse: byte completed while previous byte still unaccepted
// BEHAVIOUR
//  Reset (rst_n=0, async): rx_data=0, rx_valid=0, frame_err=0, overrun=0, both sync flops=1,
//   tick counter=0, bit/sample counters=0, shift reg=0, state=IDLE.
//  Sync: rx passes 2-flop synchroniser -> rx_s; all decisions use rx_s (2 clk input latency).
//  Tick: counter 0..TICK_DIV-1 free-running; tick=1 for one clk when count==TICK_DIV-1, then wraps to 0.
//  FSM (transitions on clk; sample counter advances only on tick):
//   IDLE  : rx_s==0 -> START, sample_cnt=0.
//   START : on tick, sample_cnt++; at sample_cnt==OVERSAMPLE/2-1: rx_s==0 -> DATA (cnt=0, bit=0),
//           else -> IDLE (glitch reject, no outputs).
//   DATA  : on tick, cnt++; at cnt==OVERSAMPLE-1: shift rx_s in at MSB (right shift, LSB first),
//           cnt=0, bit++; after bit DATA_BITS-1 -> STOP.
//   STOP  : at cnt==OVERSAMPLE-1: rx_s==1 -> deliver byte, -> IDLE;
//           rx_s==0 -> frame_err pulse, byte discarded, -> BREAK.
//   BREAK : wait until rx_s==1 -> IDLE (held-low line never retriggers).
//  Deliver: if rx_valid==0, or rx_valid & rx_ready in the same clk: rx_data<=shift reg, rx_valid<=1.
//   else: byte dropped, rx_data unchanged, rx_valid stays 1, overrun pulses 1 clk.
//  Accept: rx_valid & rx_ready with no delivery that clk -> rx_valid<=0 next clk. rx_ready ignored when rx_valid=0.
//  Latency: rx_valid rises 1 clk after the stop-bit centre sample.
//  Phase error vs. true bit centre bounded by 1 tick + 2 clk; tick counter is never reset by start detection.
//  frame_err and overrun never assert in the same clk; neither asserts rx_valid.
//  rst_n low mid-frame: all state cleared immediately; no partial byte or pulse after release.
// TESTING (bench params TICK_DIV=4, OVERSAMPLE=16 -> 64 clk/bit; rx_ready=1 unless noted)
//  1. Send 0xA5 8N1 -> exactly one rx_valid, rx_data=8'hA5, frame_err=0, overrun=0.
//  2. Pull rx low 10 clk then high -> FSM returns to IDLE, no rx_valid, no frame_err.
//  3. Send 0x3C with stop bit forced 0, then hold rx low 200 clk, then high, then send 0x55
//     -> one frame_err pulse, no valid for 0x3C, single valid with 0x55.
//  4. rx_ready=0; send 0x11 then 0x22 -> rx_data stays 8'h11, rx_valid=1, one overrun pulse;
//     raise rx_ready -> rx_valid drops next clk.
//  5. Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three valids in order, no errors.
//  6. Assert rst_n=0 during bit 4 of 0x96, release, send 0x5A -> all outputs 0 during reset,
//     only valid afterwards is 8'h5A.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (8N1 by default).
// A free-running divider produces the oversample tick. A start edge is confirmed at
// the middle of the start bit, and every later bit is sampled one full bit period
// after the previous sample. Bytes are handed to the consumer on a valid/ready
// handshake; framing errors and overruns are reported as one-clock pulses.
module uart_rx_os #(
  parameter int TICK_DIV   = 651,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SCNT_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] SCNT_ONE  = SW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 rx_meta_r, rx_sync_r, rx_s;
  logic [TW-1:0]        tick_cnt_r;
  logic                 tick_s;
  logic [2:0]           state_r, state_nxt_s;
  logic [SW-1:0]        scnt_r, scnt_nxt_s;
  logic [BW-1:0]        bit_r, bit_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                 deliver_s, stop_bad_s;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, frame_err_r, overrun_r;

  assign rx_s   = rx_sync_r;
  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Free-running oversample divider; never realigned to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= TICK_ZERO;
    end else if (tick_s) begin
      tick_cnt_r <= TICK_ZERO;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
    end
  end

  // Frame FSM next-state: start confirmation, bit sampling and stop check.
  always_comb begin
    state_nxt_s = state_r;
    scnt_nxt_s  = scnt_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    deliver_s   = 1'b0;
    stop_bad_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt_s = S_START;
          scnt_nxt_s  = SCNT_ZERO;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s && (scnt_r == HALF_LAST)) begin
          scnt_nxt_s  = SCNT_ZERO;
          bit_nxt_s   = BIT_ZERO;
          // A start bit that is high again at its centre was a glitch.
          state_nxt_s = rx_s ? S_IDLE : S_DATA;
        end else if (tick_s) begin
          scnt_nxt_s = scnt_r + SCNT_ONE;
        end else begin
          scnt_nxt_s = scnt_r;
        end
      end
      S_DATA: begin
        if (tick_s && (scnt_r == FULL_LAST)) begin
          scnt_nxt_s  = SCNT_ZERO;
          shift_nxt_s = {rx_s, shift_r[DATA_BITS-1:1]};
          if (bit_r == BIT_LAST) begin
            bit_nxt_s   = BIT_ZERO;
            state_nxt_s = S_STOP;
          end else begin
            bit_nxt_s = bit_r + BIT_ONE;
          end
        end else if (tick_s) begin
          scnt_nxt_s = scnt_r + SCNT_ONE;
        end else begin
          scnt_nxt_s = scnt_r;
        end
      end
      S_STOP: begin
        if (tick_s && (scnt_r == FULL_LAST)) begin
          scnt_nxt_s = SCNT_ZERO;
          if (rx_s) begin
            deliver_s   = 1'b1;
            state_nxt_s = S_IDLE;
          end else begin
            stop_bad_s  = 1'b1;
            state_nxt_s = S_BREAK;
          end
        end else if (tick_s) begin
          scnt_nxt_s = scnt_r + SCNT_ONE;
        end else begin
          scnt_nxt_s = scnt_r;
        end
      end
      S_BREAK: begin
        // A line held low after a bad stop bit must not look like a new start.
        if (rx_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_BREAK;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        scnt_nxt_s  = SCNT_ZERO;
        bit_nxt_s   = BIT_ZERO;
      end
    endcase
  end

  // Frame FSM state, counters and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      scnt_r  <= SCNT_ZERO;
      bit_r   <= BIT_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      scnt_r  <= scnt_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Output handshake: load a byte when the slot is free or being freed, else flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r   <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= stop_bad_s;
      overrun_r   <= deliver_s & rx_valid_r & ~rx_ready;
      if (deliver_s && (!rx_valid_r || rx_ready)) begin
        rx_data_r  <= shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os with TICK_DIV=4, OVERSAMPLE=16 (64 clk per bit).
module tb_uart_rx_os;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] got[$];

  int base_q, base_fe, base_ov;

  uart_rx_os #(
    .TICK_DIV  (4),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Record accepted bytes and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return {24'd0, got[i]};
    else return 32'hFFFF_FFFF;
  endfunction

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    idle_clks(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle_clks(BIT_CLK);
    end
    rx = stop_bit;
    idle_clks(BIT_CLK);
  endtask

  task automatic mark();
    base_q  = got.size();
    base_fe = fe_cnt;
    base_ov = ov_cnt;
  endtask

  initial begin
    logic [7:0] b96;
    // Reset state
    idle_clks(5);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    idle_clks(2 * BIT_CLK);

    // 1. single byte 0xA5
    mark();
    send_byte(8'hA5, 1'b1);
    idle_clks(2 * BIT_CLK);
    check("t1_count", got.size() - base_q, 32'd1);
    check("t1_data", got_at(base_q), 32'hA5);
    check("t1_ferr", fe_cnt - base_fe, 32'd0);
    check("t1_ovr", ov_cnt - base_ov, 32'd0);

    // 2. short glitch rejected
    mark();
    rx = 1'b0;
    idle_clks(10);
    rx = 1'b1;
    idle_clks(2 * BIT_CLK);
    check("t2_count", got.size() - base_q, 32'd0);
    check("t2_ferr", fe_cnt - base_fe, 32'd0);
    check("t2_valid", {31'd0, rx_valid}, 32'd0);

    // 3. framing error, held break, then good byte
    mark();
    send_byte(8'h3C, 1'b0);
    rx = 1'b0;
    idle_clks(200);
    rx = 1'b1;
    idle_clks(2 * BIT_CLK);
    check("t3_ferr", fe_cnt - base_fe, 32'd1);
    check("t3_nobyte", got.size() - base_q, 32'd0);
    send_byte(8'h55, 1'b1);
    idle_clks(2 * BIT_CLK);
    check("t3_count", got.size() - base_q, 32'd1);
    check("t3_data", got_at(base_q), 32'h55);
    check("t3_ferr_total", fe_cnt - base_fe, 32'd1);

    // 4. overrun with consumer stalled
    mark();
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    idle_clks(BIT_CLK);
    check("t4_valid1", {31'd0, rx_valid}, 32'd1);
    check("t4_data1", {24'd0, rx_data}, 32'h11);
    check("t4_ovr0", ov_cnt - base_ov, 32'd0);
    send_byte(8'h22, 1'b1);
    idle_clks(BIT_CLK);
    check("t4_valid2", {31'd0, rx_valid}, 32'd1);
    check("t4_data2", {24'd0, rx_data}, 32'h11);
    check("t4_ovr1", ov_cnt - base_ov, 32'd1);
    check("t4_ferr", fe_cnt - base_fe, 32'd0);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 check("t4_drop", {31'd0, rx_valid}, 32'd0);
    idle_clks(4);
    check("t4_count", got.size() - base_q, 32'd1);
    check("t4_acc_data", got_at(base_q), 32'h11);

    // 5. back-to-back frames
    mark();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    idle_clks(2 * BIT_CLK);
    check("t5_count", got.size() - base_q, 32'd3);
    check("t5_d0", got_at(base_q), 32'h00);
    check("t5_d1", got_at(base_q + 1), 32'hFF);
    check("t5_d2", got_at(base_q + 2), 32'h81);
    check("t5_ferr", fe_cnt - base_fe, 32'd0);
    check("t5_ovr", ov_cnt - base_ov, 32'd0);

    // 6. reset during bit 4 of 0x96, then 0x5A
    mark();
    b96 = 8'h96;
    rx = 1'b0;
    idle_clks(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = b96[i];
      idle_clks(BIT_CLK);
    end
    rx = b96[4];
    idle_clks(BIT_CLK / 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_rst_data", {24'd0, rx_data}, 32'd0);
    check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("t6_rst_ovr", {31'd0, overrun}, 32'd0);
    rx = 1'b1;
    idle_clks(20);
    rst_n = 1'b1;
    idle_clks(2 * BIT_CLK);
    check("t6_nopartial", got.size() - base_q, 32'd0);
    send_byte(8'h5A, 1'b1);
    idle_clks(2 * BIT_CLK);
    check("t6_count", got.size() - base_q, 32'd1);
    check("t6_data", got_at(base_q), 32'h5A);
    check("t6_ferr", fe_cnt - base_fe, 32'd0);
    check("t6_ovr", ov_cnt - base_ov, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
